// File: rtl/i2s_rx_flex_if.sv
// Serial-side inputs and word-side outputs of the flexible I2S receiver.
// master drives the pad stream and consumes words; slave is the receiver.
interface i2s_rx_flex_if #(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 6
);
  logic              in_valid;
  logic              SD;
  logic              WS;
  logic              lj;
  logic              out_valid;
  logic              out_ch;
  logic [DATA_W-1:0] out_data;
  logic [LEN_W-1:0]  out_len;
  logic              out_trunc;

  modport master (
    output in_valid, SD, WS, lj,
    input  out_valid, out_ch, out_data, out_len, out_trunc
  );

  modport slave (
    input  in_valid, SD, WS, lj,
    output out_valid, out_ch, out_data, out_len, out_trunc
  );
endinterface

// File: rtl/i2s_rx_flex.sv
// Deserialises an SD/WS bit stream (I2S or left-justified) into one tagged,
// left-aligned word per slot; long slots are truncated and flagged.
//
// state  | meaning
// S_IDLE | no stream active, waiting for the first valid bit
// S_RECV | assembling a slot; channel change or in_valid=0 completes it
module i2s_rx_flex #(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 6
) (
  input  logic          clk,
  input  logic          rst,
  i2s_rx_flex_if.slave  bus
);
  typedef enum logic {S_IDLE, S_RECV} state_t;

  localparam logic [DATA_W-1:0] MSB_ONE = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] POS_2ND = MSB_ONE >> 1;

  state_t            state_q, state_d;
  logic              mode_q, mode_d;
  logic              ws_prev_q, ws_prev_d;
  logic              ch_q, ch_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [DATA_W-1:0] pos_q, pos_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              trunc_q, trunc_d;
  logic              ov_q, ov_d;
  logic              och_q, och_d;
  logic [DATA_W-1:0] odata_q, odata_d;
  logic [LEN_W-1:0]  olen_q, olen_d;
  logic              otr_q, otr_d;
  logic              bit_ch, new_ch, start_word, done_word;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      mode_q    <= 1'b0;
      ws_prev_q <= 1'b0;
      ch_q      <= 1'b0;
      sh_q      <= '0;
      pos_q     <= '0;
      len_q     <= '0;
      trunc_q   <= 1'b0;
      ov_q      <= 1'b0;
      och_q     <= 1'b0;
      odata_q   <= '0;
      olen_q    <= '0;
      otr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      ws_prev_q <= ws_prev_d;
      ch_q      <= ch_d;
      sh_q      <= sh_d;
      pos_q     <= pos_d;
      len_q     <= len_d;
      trunc_q   <= trunc_d;
      ov_q      <= ov_d;
      och_q     <= och_d;
      odata_q   <= odata_d;
      olen_q    <= olen_d;
      otr_q     <= otr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    ws_prev_d  = ws_prev_q;
    ch_d       = ch_q;
    sh_d       = sh_q;
    pos_d      = pos_q;
    len_d      = len_q;
    trunc_d    = trunc_q;
    ov_d       = 1'b0;
    och_d      = och_q;
    odata_d    = odata_q;
    olen_d     = olen_q;
    otr_d      = otr_q;
    start_word = 1'b0;
    done_word  = 1'b0;
    new_ch     = bus.WS;
    // I2S delays the channel by one bit; left-justified uses the current WS
    bit_ch     = mode_q ? bus.WS : ws_prev_q;

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          start_word = 1'b1;
          mode_d     = bus.lj;
          state_d    = S_RECV;
        end
      end
      S_RECV: begin
        if (!bus.in_valid) begin
          done_word = 1'b1;
          state_d   = S_IDLE;
        end else if (bit_ch == ch_q) begin
          // pos_q marks the next free bit; zero means the word is already full
          if (pos_q == '0) begin
            trunc_d = 1'b1;
          end else begin
            if (bus.SD) sh_d = sh_q | pos_q;
            pos_d = pos_q >> 1;
          end
          if (len_q != '1) len_d = len_q + 1'b1;
        end else begin
          done_word  = 1'b1;
          start_word = 1'b1;
          new_ch     = bit_ch;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (bus.in_valid) ws_prev_d = bus.WS;

    if (done_word) begin
      ov_d    = 1'b1;
      och_d   = ch_q;
      odata_d = sh_q;
      olen_d  = len_q;
      otr_d   = trunc_q;
    end

    if (start_word) begin
      ch_d    = new_ch;
      sh_d    = bus.SD ? MSB_ONE : '0;
      pos_d   = POS_2ND;
      len_d   = LEN_W'(1);
      trunc_d = 1'b0;
    end
  end

  assign bus.out_valid = ov_q;
  assign bus.out_ch    = och_q;
  assign bus.out_data  = odata_q;
  assign bus.out_len   = olen_q;
  assign bus.out_trunc = otr_q;
endmodule

// File: tb/tb_i2s_rx_flex.sv
// Bench for i2s_rx_flex: directed stream table with hand-derived words,
// a mid-slot reset sequence, then random streams against a slot-level model.
module tb_i2s_rx_flex;
  localparam int DW = 8;
  localparam int LW = 5;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  i2s_rx_flex_if #(.DATA_W(DW), .LEN_W(LW)) bus ();
  i2s_rx_flex #(.DATA_W(DW), .LEN_W(LW)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        lj;
    int          n;
    logic [63:0] sd;
    logic [63:0] ws;
  } vec_t;

  typedef struct {
    int          id;
    logic        ch;
    logic [7:0]  data;
    logic [4:0]  len;
    logic        trunc;
    int          last;
  } xtab_t;

  typedef struct {
    int          cyc;
    logic        ch;
    logic [7:0]  data;
    logic [4:0]  len;
    logic        trunc;
  } exp_t;

  vec_t  vecs[10];
  xtab_t xtab[$];
  exp_t  q[$];
  int    vectors = 0;
  int    miscompares = 0;

  logic       l_ch = 1'b0;
  logic [7:0] l_data = '0;
  logic [4:0] l_len = '0;
  logic       l_trunc = 1'b0;

  // Scoreboard: every cycle either a word is due, or outputs must hold.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      vectors++;
      q.delete();
      l_ch = 1'b0; l_data = '0; l_len = '0; l_trunc = 1'b0;
      if (bus.out_valid !== 1'b0 || bus.out_ch !== 1'b0 || bus.out_data !== 8'h00 ||
          bus.out_len !== 5'd0 || bus.out_trunc !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_outputs cyc=%0d: got v=%0d ch=%0d data=%02h len=%0d trunc=%0d, want all 0",
                 cyc, bus.out_valid, bus.out_ch, bus.out_data, bus.out_len, bus.out_trunc);
      end
    end else if (bus.out_valid === 1'b1) begin
      vectors++;
      if (q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_word cyc=%0d: got ch=%0d data=%02h len=%0d, want no word",
                 cyc, bus.out_ch, bus.out_data, bus.out_len);
      end else begin
        e = q.pop_front();
        if (e.cyc != cyc || bus.out_ch !== e.ch || bus.out_data !== e.data ||
            bus.out_len !== e.len || bus.out_trunc !== e.trunc) begin
          miscompares++;
          $display("FAIL word: got cyc=%0d ch=%0d data=%02h len=%0d trunc=%0d, want cyc=%0d ch=%0d data=%02h len=%0d trunc=%0d",
                   cyc, bus.out_ch, bus.out_data, bus.out_len, bus.out_trunc,
                   e.cyc, e.ch, e.data, e.len, e.trunc);
        end
        l_ch = e.ch; l_data = e.data; l_len = e.len; l_trunc = e.trunc;
      end
    end else begin
      vectors++;
      if (bus.out_valid !== 1'b0 || bus.out_ch !== l_ch || bus.out_data !== l_data ||
          bus.out_len !== l_len || bus.out_trunc !== l_trunc) begin
        miscompares++;
        $display("FAIL hold cyc=%0d: got v=%0d ch=%0d data=%02h len=%0d trunc=%0d, want v=0 ch=%0d data=%02h len=%0d trunc=%0d",
                 cyc, bus.out_valid, bus.out_ch, bus.out_data, bus.out_len, bus.out_trunc,
                 l_ch, l_data, l_len, l_trunc);
      end
      if (q.size() > 0) begin
        vectors++;
        if (q[0].cyc <= cyc) begin
          miscompares++;
          $display("FAIL missing_word cyc=%0d: got no out_valid, want ch=%0d data=%02h len=%0d at cyc=%0d",
                   cyc, q[0].ch, q[0].data, q[0].len, q[0].cyc);
          void'(q.pop_front());
        end
      end
    end
  end

  // Slot-level reference: label each bit with its channel, cut into runs.
  function automatic void model_push(input vec_t v, input int start);
    logic chs[64];
    int   a;
    int   slen;
    logic [7:0] d;
    for (int k = 0; k < v.n; k++) begin
      if (k == 0)     chs[k] = v.ws[v.n-1];
      else if (v.lj)  chs[k] = v.ws[v.n-1-k];
      else            chs[k] = v.ws[v.n-k];
    end
    a = 0;
    for (int k = 0; k < v.n; k++) begin
      if (k == v.n-1 || chs[k+1] != chs[k]) begin
        slen = k - a + 1;
        d = '0;
        for (int j = 0; j < slen && j < DW; j++) d[DW-1-j] = v.sd[v.n-1-(a+j)];
        q.push_back('{start + k + 2, chs[k], d, 5'((slen > 31) ? 31 : slen), (slen > DW)});
        a = k + 1;
      end
    end
  endfunction

  task automatic run_stream(input vec_t v, input bit use_model, input int id);
    int start;
    @(posedge clk); #1;
    start = cyc;
    if (use_model) model_push(v, start);
    else begin
      foreach (xtab[i])
        if (xtab[i].id == id)
          q.push_back('{start + xtab[i].last + 2, xtab[i].ch, xtab[i].data, xtab[i].len, xtab[i].trunc});
    end
    for (int k = 0; k < v.n; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      bus.in_valid = 1'b1;
      bus.SD       = v.sd[v.n-1-k];
      bus.WS       = v.ws[v.n-1-k];
      bus.lj       = (k == 0) ? v.lj : ~v.lj;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.SD       = 1'($urandom);
    bus.WS       = 1'($urandom);
    bus.lj       = 1'($urandom);
  endtask

  task automatic wait_drain();
    int t = 0;
    while (q.size() > 0 && t < 200) begin @(posedge clk); t++; end
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d words still pending, want 0", q.size());
    end
  endtask

  initial begin
    vec_t v;
    logic w;

    vecs[0] = '{1'b1, 16, 64'hA53C, 64'h00FF};
    vecs[1] = '{1'b0, 16, 64'hA53C, 64'h01FE};
    vecs[2] = '{1'b1, 6,  64'b101101, 64'b000001};
    vecs[3] = '{1'b1, 10, 64'b1100110011, 64'h3FF};
    vecs[4] = '{1'b1, 6,  64'b101010, 64'b010101};
    vecs[5] = '{1'b0, 4,  64'b1101, 64'b1000};
    vecs[6] = '{1'b1, 40, 64'hFF_FFFF_FFFF, 64'h0};
    vecs[7] = '{1'b1, 8,  64'h5A, 64'h0};
    vecs[8] = '{1'b1, 9,  64'b101100111, 64'h0};
    vecs[9] = '{1'b0, 16, 64'hA53C, 64'h01FE};
    xtab.push_back('{0, 1'b0, 8'hA5, 5'd8,  1'b0, 7});
    xtab.push_back('{0, 1'b1, 8'h3C, 5'd8,  1'b0, 15});
    xtab.push_back('{1, 1'b0, 8'hA5, 5'd8,  1'b0, 7});
    xtab.push_back('{1, 1'b1, 8'h3C, 5'd8,  1'b0, 15});
    xtab.push_back('{2, 1'b0, 8'hB0, 5'd5,  1'b0, 4});
    xtab.push_back('{2, 1'b1, 8'h80, 5'd1,  1'b0, 5});
    xtab.push_back('{3, 1'b1, 8'hCC, 5'd10, 1'b1, 9});
    for (int k = 0; k < 6; k++)
      xtab.push_back('{4, 1'(k % 2), (k % 2) ? 8'h00 : 8'h80, 5'd1, 1'b0, k});
    xtab.push_back('{5, 1'b1, 8'hC0, 5'd2,  1'b0, 1});
    xtab.push_back('{5, 1'b0, 8'h40, 5'd2,  1'b0, 3});
    xtab.push_back('{6, 1'b0, 8'hFF, 5'd31, 1'b1, 39});
    xtab.push_back('{7, 1'b0, 8'h5A, 5'd8,  1'b0, 7});
    xtab.push_back('{8, 1'b0, 8'hB3, 5'd9,  1'b1, 8});
    xtab.push_back('{9, 1'b0, 8'hA5, 5'd8,  1'b0, 7});
    xtab.push_back('{9, 1'b1, 8'h3C, 5'd8,  1'b0, 15});

    rst = 1'b1;
    bus.in_valid = 1'b0; bus.SD = 1'b0; bus.WS = 1'b0; bus.lj = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 10; i++) begin
      run_stream(vecs[i], 1'b0, i);
      repeat (i % 3) @(posedge clk);
    end
    wait_drain();

    // Reset four bits into a slot: nothing may come out, outputs clear.
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      bus.in_valid = 1'b1; bus.lj = 1'b1; bus.WS = 1'b0; bus.SD = 1'(k % 2);
    end
    @(posedge clk); #1;
    rst = 1'b1; bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    run_stream(vecs[0], 1'b0, 0);
    wait_drain();

    for (int i = 0; i < 60; i++) begin
      v.lj = 1'($urandom);
      v.n  = $urandom_range(1, 40);
      v.sd = {$urandom, $urandom};
      v.ws = '0;
      w    = 1'($urandom);
      for (int k = 0; k < v.n; k++) begin
        if ($urandom_range(0, 5) == 0) w = ~w;
        v.ws[v.n-1-k] = w;
      end
      run_stream(v, 1'b1, -1);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: got no end of test, want finish within bound");
    $fatal(1);
  end
endmodule

// File: doc/i2s_rx_flex.md
Name: i2s_rx_flex

Overview:
Parametrised serial audio receiver. Deserialises a one-bit-per-cycle SD/WS stream into per-channel words, in either I2S or left-justified framing. Data width and slot length are parametrised: short slots are zero-padded and long slots are truncated and flagged. Emits one tagged word per slot and sits between the serial pad interface and the audio sample pipeline.

Parameters:
DATA_W, 32, width of out_data (bits kept per slot, MSB-first)
LEN_W, 6, width of out_len; slot bit counter saturates at 2^LEN_W-1

Ports:
clk  in  1  clock; one serial bit period per cycle with in_valid=1
rst  in  1  asynchronous, active-high reset
in_valid  in  1  SD/WS valid this cycle; a contiguous run of 1s is one stream
SD  in  1  serial data, MSB-first
WS  in  1  word select: 0 = left (ch0), 1 = right (ch1)
lj  in  1  framing: 0 = I2S (one-bit delay), 1 = left-justified; sampled on the first bit of a stream
out_valid  out  1  one-cycle pulse per completed word
out_ch  out  1  channel of the word
out_data  out  DATA_W  word, left-aligned
out_len  out  LEN_W  bits received in the slot, saturating
out_trunc  out  1  slot had more than DATA_W bits

Behaviour:
- Reset: all outputs 0, FSM IDLE, partial word discarded. Reset mid-word produces no out_valid. Operation resumes on the first in_valid after rst falls.
- Outputs are registered. out_ch, out_data, out_len and out_trunc hold their last values while out_valid=0.
- Channel of bit k within a stream:
  - lj=1: WS sampled with bit k.
  - lj=0: WS sampled with bit k-1.
  - The first bit of a stream always uses its own WS.
- mode_q latches lj on the first bit of a stream. Changes to lj mid-stream are ignored.
- FSM IDLE:
  - in_valid=1 -> RECV. The bit is loaded as bit 1 of a new word, len=1.
  - Otherwise stay in IDLE.
- FSM RECV, each cycle:
  - in_valid=1 and the channel equals the current word's channel: append the bit, len+1.
  - in_valid=1 and the channel differs: complete the current word and start a new word with this bit (len=1). No bit is lost, so slots run back to back.
  - in_valid=0: complete (flush) the current word -> IDLE.
- Completion timing: completion is detected in the cycle of the first bit of the next slot, or in the first in_valid=0 cycle. out_valid is asserted in the following cycle, so latency is 2 cycles after the slot's last bit. Sustained throughput is one word per cycle (1-bit slots).
- Word assembly:
  - Bit i of a slot (i=1..) goes to out_data[DATA_W-i] for i<=DATA_W.
  - Unfilled LSBs are 0.
  - Bits beyond DATA_W are dropped and set out_trunc=1.
  - out_len = min(slot bits, 2^LEN_W-1).
- Simultaneous events:
  - A completion in RECV with in_valid=1 and a channel change reloads the shift register with the new bit in the same cycle.
  - A new stream starting the cycle after a flush is handled normally from IDLE.
- Width rule: the shift register is DATA_W bits plus a saturating LEN_W counter. No arithmetic wraps.

Test Plan:
All scenarios use DATA_W=8 and LEN_W=5.
1. lj=1, 16 valid bits, WS=0 for bits 0-7 and 1 for bits 8-15, SD=0xA5 then 0x3C, then in_valid=0 -> out_valid {ch0, 0xA5, len8, trunc0} two cycles after bit 7, then {ch1, 0x3C, len8} two cycles after bit 15.
2. lj=0, same SD, WS=0 on bits 0-6, 1 on bits 7-14, 0 on bit 15 -> identical two words and timing as scenario 1.
3. lj=1, 5-bit ch0 slot SD=10110 then a WS change -> {ch0, 0xB0, len5, trunc0}.
4. lj=1, 10-bit ch1 slot SD=1100110011 then in_valid=0 -> {ch1, 0xCC, len10, trunc1}.
5. Assert rst after 4 bits of a slot -> no out_valid and all outputs 0. A following stream per scenario 1 decodes correctly.
6. lj=1, WS toggling every bit, SD=1,0,1,... for 6 bits -> out_valid on 6 consecutive cycles, len1, data alternating 0x80 and 0x00, ch alternating 0 and 1.
